uart_tx_scheduler: RTL
======================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter DBITS, default 8, bits per UART word.
REQ-003 SHALL have parameter MSG_BYTES, default 4, words per message.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 2_000_000, tx_done watchdog limit (used only when UART_SCHED_TIMEOUT_EN is defined).
REQ-005 SHALL have port clk_100MHz  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port req  input  NREQ  per-requester message request, level.
REQ-008 SHALL have port req_data  input  NREQ*DBITS*MSG_BYTES  message of requester i at slice [i*DBITS*MSG_BYTES +: DBITS*MSG_BYTES].
REQ-009 SHALL have port grant  output  NREQ  one-hot owner of the transmitter, zero when idle.
REQ-010 SHALL have port done  output  NREQ  one-cycle pulse to owner on message completion.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port tx_start  output  1  one-cycle start pulse to uart_transmitter.
REQ-013 SHALL have port tx_data  output  DBITS  word to uart_transmitter, stable from tx_start until tx_done.
REQ-014 SHALL have port tx_done  input  1  one-cycle pulse from uart_transmitter on stop-bit end.
REQ-015 SHALL have port err  output  1  one-cycle pulse on watchdog abort (tied 0 when feature excluded).

Function
REQ-016 SHALL implement states IDLE, START, WAIT, FINISH; all outputs registered.
REQ-017 IDLE: when any req bit is high at an edge, SHALL select winner, set grant, capture winner's req_data into a message shift register, load word counter with MSG_BYTES, go to START.
REQ-018 Arbitration SHALL be round-robin: search starts at index (last winner + 1) mod NREQ; after reset last winner = NREQ-1, so requester 0 wins first.
REQ-019 START: tx_start SHALL be high for exactly this one cycle, tx_data = most significant DBITS of the shift register; next state WAIT.
REQ-020 WAIT: on tx_done, if counter = 1 go to FINISH, else decrement counter, shift register left by DBITS, go to START.
REQ-021 Latency: req sampled high at edge k -> tx_start high in cycle k+1; tx_done at edge m -> next tx_start in cycle m+1.
REQ-022 Message words SHALL be sent MSB word first (bits [DBITS*MSG_BYTES-1 -: DBITS] first).
REQ-023 FINISH: done[winner] SHALL pulse one cycle, grant cleared, last-winner updated, next state IDLE; new arbitration no earlier than the following edge.
REQ-024 req deassertion while granted SHALL NOT abort the message; req_data changes after capture SHALL have no effect.
REQ-025 tx_done in IDLE, START or FINISH SHALL be ignored.
REQ-026 Simultaneous requests SHALL be resolved by REQ-018 only; no requester waits more than NREQ-1 messages.

Reset
REQ-027 reset_n low SHALL immediately force IDLE, grant=0, done=0, busy=0, tx_start=0, tx_data=0, err=0, counter=0, watchdog=0, last winner=NREQ-1, including mid-message (message dropped, no done).

Configuration
REQ-028 With UART_SCHED_TIMEOUT_EN defined, a watchdog SHALL count cycles in WAIT, clear on each tx_done, and on reaching TIMEOUT_CYCLES pulse err and done[winner] for one cycle and return to IDLE via FINISH.
REQ-029 Without UART_SCHED_TIMEOUT_EN, no watchdog logic SHALL exist, err SHALL be constant 0, WAIT waits indefinitely.

Structure
REQ-030 Shared package uart_pkg SHALL hold the state enum (IDLE/START/WAIT/FINISH) and default constants DBITS=8, MSG_BYTES=4.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, last; output one-hot grant).

Verification (transmitter model returns tx_done 20 cycles after tx_start)
REQ-032 req=01, req_data[31:0]=0x41424344 -> tx_data 0x41,0x42,0x43,0x44 with 4 tx_start pulses, then done=01 one cycle, busy low after.
REQ-033 req=11 held -> order of grants 0,1,0,1; done alternates 01,10.
REQ-034 reset_n low during 2nd word of requester 1 -> all outputs 0 immediately; after release req=10 -> requester 0 not favoured incorrectly: next grant = 01 if req=11.
REQ-035 req pulsed high one cycle then low -> full 4-word message still sent, done pulses.
REQ-036 UART_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=50, model never returns tx_done -> err and done pulse at 50th WAIT cycle, state IDLE next.
REQ-037 Spurious tx_done in IDLE -> no outputs change.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared scheduler state encoding and default word/message sizing.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam int UART_DBITS     = 8;
    localparam int UART_MSG_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Round-robin one-hot selector, search begins just after 'last'.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [NREQ-1:0]         grant
);

    localparam int LW = $clog2(NREQ);

    logic [LW-1:0] idx;
    logic          found;

    // Explicit wrap keeps non-power-of-two requester counts correct.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = last;
        for (int i = 0; i < NREQ; i++) begin
            idx = (idx == LW'(NREQ - 1)) ? '0 : idx + LW'(1);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
// Module : uart_tx_scheduler
// Brief  : Arbitrates multi-word messages from NREQ requesters onto one UART.
// Macro  : UART_SCHED_TIMEOUT_EN adds a tx_done watchdog that raises err.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NREQ           = 2,
    parameter int DBITS          = UART_DBITS,
    parameter int MSG_BYTES      = UART_MSG_BYTES,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                            clk_100MHz,
    input  logic                            reset_n,
    input  logic [NREQ-1:0]                 req,
    input  logic [NREQ*DBITS*MSG_BYTES-1:0] req_data,
    output logic [NREQ-1:0]                 grant,
    output logic [NREQ-1:0]                 done,
    output logic                            busy,
    output logic                            tx_start,
    output logic [DBITS-1:0]                tx_data,
    input  logic                            tx_done,
    output logic                            err
);

    localparam int MSG_W = DBITS * MSG_BYTES;
    localparam int LW    = $clog2(NREQ);
    localparam int CW    = $clog2(MSG_BYTES + 1);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("uart_tx_scheduler: NREQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    state_t           state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d, done_q, done_d, arb_grant;
    logic [LW-1:0]    last_q, last_d, win_q, win_d, arb_idx;
    logic [MSG_W-1:0] shift_q, shift_d, arb_data;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DBITS-1:0] txd_q, txd_d;
    logic             busy_q, busy_d, start_q, start_d;
    logic             timeout;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req),
        .last  (last_q),
        .grant (arb_grant)
    );

    always_comb begin
        arb_idx  = '0;
        arb_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
                arb_idx  = LW'(i);
                arb_data = req_data[i*MSG_W +: MSG_W];
            end
        end
    end

`ifdef UART_SCHED_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WW-1:0] wd_q, wd_d;
    logic          err_q;

    // Watchdog only runs while waiting for the transmitter; any tx_done restarts it.
    assign timeout = (state_q == WAIT) && !tx_done && (wd_q == WW'(TIMEOUT_CYCLES - 1));
    assign wd_d    = ((state_q == WAIT) && !tx_done && !timeout) ? wd_q + WW'(1) : '0;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= timeout;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            last_q  <= LW'(NREQ - 1);
            win_q   <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            txd_q   <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            last_q  <= last_d;
            win_q   <= win_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = START;
            START:   state_d = WAIT;
            WAIT: begin
                if (tx_done)      state_d = (cnt_q == CW'(1)) ? FINISH : START;
                else if (timeout) state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d = grant_q;
        done_d  = '0;
        last_d  = last_q;
        win_d   = win_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        txd_d   = txd_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = arb_grant;
                    win_d   = arb_idx;
                    shift_d = arb_data;
                    cnt_d   = CW'(MSG_BYTES);
                end
            end
            WAIT: begin
                if (tx_done && cnt_q != CW'(1)) begin
                    cnt_d   = cnt_q - CW'(1);
                    shift_d = shift_q << DBITS;
                end
            end
            FINISH: begin
                grant_d = '0;
                last_d  = win_q;
            end
            default: ;
        endcase
        if (state_q == WAIT && state_d == FINISH) done_d = grant_q;
        // tx_data is refreshed only when entering START, so it holds through WAIT.
        if (state_d == START) txd_d = shift_d[MSG_W-1 -: DBITS];
        start_d = (state_d == START);
        busy_d  = (state_d != IDLE);
    end

    assign grant    = grant_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign tx_start = start_q;
    assign tx_data  = txd_q;

endmodule

`default_nettype wire
